// File: rtl/boot_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg
//   Shared definitions for the instruction-memory boot loader: loader state
//   encoding, image header width, byte ordering of the host stream, and the
//   small helpers that classify a state as a high-byte or low-byte phase.
// ---------------------------------------------------------------------------
package boot_pkg;

  // Width of the word-count header that precedes the image.
  localparam int HDR_W = 16;

  // Width of one instruction word as assembled from two host bytes.
  localparam int WORD_W = 16;

  // Host sends the high byte of every 16-bit quantity first.
  localparam bit BYTE_ORDER_HI_FIRST = 1'b1;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DAT_HI = 3'd2,
    DAT_LO = 3'd3,
    DONE   = 3'd4
  } boot_state_t;

  // The header and the data words share the same hi/lo byte pairing.
  function automatic logic is_hi_phase(boot_state_t s);
    return (s == LEN_HI) || (s == DAT_HI);
  endfunction

  function automatic logic is_lo_phase(boot_state_t s);
    return (s == LEN_LO) || (s == DAT_LO);
  endfunction

endpackage

// File: rtl/byte_pair_packer.sv
// ---------------------------------------------------------------------------
// byte_pair_packer
//   Joins two consecutive host bytes into one 16-bit word. The first byte of
//   a pair is held in a register; the word is presented combinationally
//   together with word_valid while the second byte is on the input.
// Ports
//   clk, reset   clock, synchronous active-high reset
//   hi_en        first byte of a pair is being accepted
//   lo_en        second byte of a pair is being accepted
//   in_byte      host byte
//   word         assembled word (valid while word_valid is high)
//   word_valid   strobe, high in the cycle the second byte is accepted
// ---------------------------------------------------------------------------
module byte_pair_packer
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              hi_en,
  input  logic              lo_en,
  input  logic [7:0]        in_byte,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [7:0] first_q;

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_q <= '0;
    end else if (hi_en) begin
      first_q <= in_byte;
    end
  end

  always_comb begin
    if (BYTE_ORDER_HI_FIRST) begin
      word = {first_q, in_byte};
    end else begin
      word = {in_byte, first_q};
    end
    word_valid = lo_en;
  end

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//   Streams a program image from a host byte link into instruction memory
//   while holding the processor in reset. Stream: LEN_HI, LEN_LO (word count
//   N), then N words high byte first. Words beyond the memory depth are
//   consumed but not written and flag err.
// Ports
//   clk, reset     clock, synchronous active-high reset
//   start          re-arms a new load when in DONE (ignored otherwise)
//   in_valid       host byte valid
//   in_data        host byte
//   in_ready       loader accepts a byte this cycle (low only in DONE)
//   imem_we        instruction memory write strobe (registered)
//   imem_addr      word address of the write
//   imem_wdata     word data of the write
//   cpu_reset      processor reset, released one cycle after done rises
//   busy           load in progress
//   done           image complete
//   err            header count exceeded memory depth (sticky until reset/start)
//   words_loaded   words actually written, saturates at the memory depth
// ---------------------------------------------------------------------------
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  // Memory depth, widened so it compares against a full 16-bit header.
  localparam logic [HDR_W:0] DEPTH = (HDR_W + 1)'(1) << ADDR_W;

  boot_state_t       state, state_nx;
  logic              accept;
  logic              restart;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic [HDR_W-1:0]  len_q;
  logic [HDR_W-1:0]  word_idx;
  logic              last_word;
  logic              in_range;

  always_comb begin
    in_ready  = (state != DONE);
    accept    = in_valid && in_ready;
    restart   = (state == DONE) && start;
    last_word = (word_idx == len_q - 1'b1);
    in_range  = ({1'b0, word_idx} < DEPTH);
    done      = (state == DONE);
    busy      = (state != DONE);
  end

  byte_pair_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .hi_en      (accept && is_hi_phase(state)),
    .lo_en      (accept && is_lo_phase(state)),
    .in_byte    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LEN_HI;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: state_nx gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      LEN_HI: if (accept) state_nx = LEN_LO;
      LEN_LO: if (accept) state_nx = (word == '0) ? DONE : DAT_HI;
      DAT_HI: if (accept) state_nx = DAT_LO;
      DAT_LO: if (accept) state_nx = last_word ? DONE : DAT_HI;
      DONE:   if (start)  state_nx = LEN_HI;
      default:            state_nx = LEN_HI;
    endcase
  end

  // NOTE: every register here, data included, is reset so that a reset
  // mid-load returns all outputs to a known state on the next edge; the
  // memory array itself is outside this block and keeps its contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q        <= '0;
      word_idx     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      err          <= 1'b0;
      cpu_reset    <= 1'b1;
    end else begin
      imem_we <= 1'b0;
      // Released only after a full cycle in DONE, so the final write has
      // committed; a restart re-asserts it right away.
      cpu_reset <= !((state == DONE) && !start);

      if (restart) begin
        err          <= 1'b0;
        words_loaded <= '0;
      end

      if ((state == LEN_LO) && accept) begin
        len_q    <= word;
        word_idx <= '0;
        err      <= ({1'b0, word} > DEPTH);
      end

      if ((state == DAT_LO) && word_valid) begin
        word_idx <= word_idx + 1'b1;
        // Out-of-range words are drained from the link without a write.
        if (in_range) begin
          imem_we      <= 1'b1;
          imem_addr    <= ADDR_W'(word_idx);
          imem_wdata   <= DATA_W'(word);
          words_loaded <= words_loaded + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//   Directed streams into two loader instances (depth 256 and depth 4).
//   Expected memory writes are queued when stimulus is issued; independent
//   monitors pop and compare on every imem_we pulse.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: ADDR_W = 8
  logic        reset = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, imem_we, cpu_reset, busy, done, err;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [8:0]  words_loaded;

  // Instance B: ADDR_W = 2
  logic        b_reset = 1'b1, b_start = 1'b0, b_in_valid = 1'b0;
  logic [7:0]  b_in_data = '0;
  logic        b_in_ready, b_imem_we, b_cpu_reset, b_busy, b_done, b_err;
  logic [1:0]  b_imem_addr;
  logic [15:0] b_imem_wdata;
  logic [2:0]  b_words_loaded;

  imem_boot_loader #(.ADDR_W(8), .DATA_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  imem_boot_loader #(.ADDR_W(2), .DATA_W(16)) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .in_valid(b_in_valid),
    .in_data(b_in_data), .in_ready(b_in_ready), .imem_we(b_imem_we),
    .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata), .cpu_reset(b_cpu_reset),
    .busy(b_busy), .done(b_done), .err(b_err), .words_loaded(b_words_loaded)
  );

  int  n_checks = 0;
  int  n_pass   = 0;
  wr_t exp_a[$];
  wr_t exp_b[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic push(input bit tgt, input logic [7:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    if (tgt) exp_b.push_back(w);
    else     exp_a.push_back(w);
  endtask

  // Scoreboard monitors: compare every write strobe against the queue.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_a.size() == 0) begin
        check("extra imem_we A", imem_we, 1'b0);
      end else begin
        wr_t e;
        e = exp_a.pop_front();
        check("write addr A", imem_addr, e.addr);
        check("write data A", imem_wdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (b_imem_we === 1'b1) begin
      if (exp_b.size() == 0) begin
        check("extra imem_we B", b_imem_we, 1'b0);
      end else begin
        wr_t e;
        e = exp_b.pop_front();
        check("write addr B", {6'b0, b_imem_addr}, e.addr);
        check("write data B", b_imem_wdata, e.data);
      end
    end
  end

  // All drives happen 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input bit tgt, input logic [7:0] b, input int gap);
    int t;
    if (tgt) b_in_valid = 1'b0;
    else     in_valid   = 1'b0;
    repeat (gap) tick();
    if (tgt) begin b_in_valid = 1'b1; b_in_data = b; end
    else     begin in_valid   = 1'b1; in_data   = b; end
    t = 0;
    while (!(tgt ? b_in_ready : in_ready) && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) check("in_ready timeout", tgt ? b_in_ready : in_ready, 1'b1);
    tick();
    if (tgt) b_in_valid = 1'b0;
    else     in_valid   = 1'b0;
  endtask

  task automatic send_stream_a(input logic [7:0] bytes[$], input int gap);
    foreach (bytes[i]) send_byte(1'b0, bytes[i], gap);
  endtask

  task automatic pulse_start_a(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " cpu_reset reasserted"}, cpu_reset, 1'b1);
    check({tag, " busy after start"}, busy, 1'b1);
    check({tag, " done cleared"}, done, 1'b0);
    check({tag, " err cleared"}, err, 1'b0);
    check({tag, " words_loaded cleared"}, words_loaded, 9'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    logic [7:0] s[$];

    // ---------------- reset values ----------------
    repeat (2) tick();
    check("rst busy", busy, 1'b1);
    check("rst cpu_reset", cpu_reset, 1'b1);
    check("rst in_ready", in_ready, 1'b1);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    check("rst imem_we", imem_we, 1'b0);
    check("rst imem_addr", imem_addr, 8'd0);
    check("rst imem_wdata", imem_wdata, 16'd0);
    check("rst words_loaded", words_loaded, 9'd0);
    check("rst B busy", b_busy, 1'b1);
    reset   = 1'b0;
    b_reset = 1'b0;
    tick();

    // ---------------- T1: 3-word image, back to back ----------------
    push(0, 8'd0, 16'h1234);
    push(0, 8'd1, 16'hABCD);
    push(0, 8'd2, 16'h0007);
    s = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07};
    send_stream_a(s, 0);
    check("t1 done on final write", done, 1'b1);
    check("t1 busy low", busy, 1'b0);
    check("t1 imem_we with done", imem_we, 1'b1);
    check("t1 cpu_reset still high", cpu_reset, 1'b1);
    check("t1 words_loaded", words_loaded, 9'd3);
    check("t1 in_ready low in DONE", in_ready, 1'b0);
    tick();
    check("t1 cpu_reset falls", cpu_reset, 1'b0);
    check("t1 done holds", done, 1'b1);
    check("t1 imem_we single pulse", imem_we, 1'b0);
    repeat (3) tick();
    check("t1 pending writes", exp_a.size(), 0);

    // ---------------- T2: same image with 3 idle cycles between bytes ----------------
    pulse_start_a("t2");
    push(0, 8'd0, 16'h1234);
    push(0, 8'd1, 16'hABCD);
    push(0, 8'd2, 16'h0007);
    send_stream_a(s, 3);
    check("t2 done", done, 1'b1);
    check("t2 words_loaded", words_loaded, 9'd3);
    repeat (4) tick();
    check("t2 cpu_reset released", cpu_reset, 1'b0);
    check("t2 pending writes", exp_a.size(), 0);

    // ---------------- T3: empty image ----------------
    pulse_start_a("t3");
    s = '{8'h00, 8'h00};
    send_stream_a(s, 0);
    t = 0;
    while (!done && t < 2) begin
      tick();
      t++;
    end
    check("t3 done for zero length", done, 1'b1);
    check("t3 words_loaded", words_loaded, 9'd0);
    check("t3 no write", imem_we, 1'b0);
    check("t3 err", err, 1'b0);
    repeat (3) tick();

    // ---------------- T4: reset after 2 of 3 words, then fresh load ----------------
    pulse_start_a("t4");
    push(0, 8'd0, 16'h1234);
    push(0, 8'd1, 16'h5678);
    s = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78};
    send_stream_a(s, 0);
    check("t4 busy mid-load", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4 busy after reset", busy, 1'b1);
    check("t4 cpu_reset after reset", cpu_reset, 1'b1);
    check("t4 words_loaded after reset", words_loaded, 9'd0);
    check("t4 done after reset", done, 1'b0);
    check("t4 imem_we after reset", imem_we, 1'b0);
    push(0, 8'd0, 16'hCAFE);
    s = '{8'h00, 8'h01, 8'hCA, 8'hFE};
    send_stream_a(s, 0);
    check("t4 fresh done", done, 1'b1);
    check("t4 fresh words_loaded", words_loaded, 9'd1);
    repeat (3) tick();
    check("t4 pending writes", exp_a.size(), 0);

    // ---------------- T5: restart, start during load is ignored ----------------
    pulse_start_a("t5");
    push(0, 8'd0, 16'hBEEF);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h01, 0);
    start = 1'b1;
    send_byte(0, 8'hBE, 0);
    start = 1'b0;
    check("t5 busy after ignored start", busy, 1'b1);
    check("t5 cpu_reset held", cpu_reset, 1'b1);
    send_byte(0, 8'hEF, 0);
    check("t5 done", done, 1'b1);
    check("t5 words_loaded", words_loaded, 9'd1);
    repeat (3) tick();
    check("t5 pending writes", exp_a.size(), 0);

    // ---------------- T6: overflow on a 4-word memory ----------------
    push(1, 8'd0, 16'h1111);
    push(1, 8'd1, 16'h2222);
    push(1, 8'd2, 16'h3333);
    push(1, 8'd3, 16'h4444);
    send_byte(1, 8'h00, 0);
    send_byte(1, 8'h05, 0);
    check("t6 err after header", b_err, 1'b1);
    send_byte(1, 8'h11, 0); send_byte(1, 8'h11, 0);
    send_byte(1, 8'h22, 0); send_byte(1, 8'h22, 0);
    send_byte(1, 8'h33, 0); send_byte(1, 8'h33, 0);
    send_byte(1, 8'h44, 0); send_byte(1, 8'h44, 0);
    check("t6 busy before 5th word", b_busy, 1'b1);
    send_byte(1, 8'h55, 0); send_byte(1, 8'h55, 0);
    check("t6 done", b_done, 1'b1);
    check("t6 5th word not written", b_imem_we, 1'b0);
    check("t6 words_loaded saturates", b_words_loaded, 3'd4);
    check("t6 err sticky", b_err, 1'b1);
    repeat (3) tick();
    check("t6 pending writes", exp_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
